// File: rtl/mem_responder_pkg.sv
// Shared definitions for the boot-loaded byte-banked memory responder:
// lane count, FSM state encoding and byte-lane helpers.
package mem_responder_pkg;

  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = LANES * BYTE_W;

  // Lane 0 is the most significant byte of a big-endian word.
  localparam int LANE_MSB   = 0;
  localparam int LANE_LSB   = LANES - 1;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte j of a big-endian word (j = 0 selects bits 31:24).
  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_IDX_W-1:0] j);
    return word[BYTE_W*(LANE_LSB-int'(j)) +: BYTE_W];
  endfunction

  // Bank holding lane j of an access whose low address bits are rot.
  function automatic logic [LANE_IDX_W-1:0] lane_bank(input logic [LANE_IDX_W-1:0] rot,
                                                       input logic [LANE_IDX_W-1:0] j);
    return rot + j;
  endfunction

endpackage

// File: rtl/mem_responder_byte_bank.sv
// One byte-wide bank: synchronous single-port RAM, read returns the
// contents before any write in the same cycle. Contents are never reset.
module byte_bank #(
  parameter int ROW_W = 10
) (
  input  logic             i_clk,
  input  logic [ROW_W-1:0] i_addr,
  input  logic             i_we,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata
);

  localparam int DEPTH = 1 << ROW_W;

  logic [7:0] r_mem [DEPTH];

  // Write on we; registered read always samples the old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: a loader streams a boot image byte by byte while the
// CPU is held; afterwards the CPU gets single-cycle 32-bit big-endian
// reads/writes at any byte alignment, wrapping modulo MEM_BYTES.
//
// Loader handshake: ld_ready is high for the whole LOAD state and low in
// RUN; a byte transfers at a posedge where ld_valid and ld_ready are both
// high. ld_last is only meaningful on a transferring cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int M_WIDTH   = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [M_WIDTH-1:0]           addr,
  input  logic [31:0]                  data_in,
  output logic [31:0]                  data_out,
  input  logic                         we,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [7:0]                   ld_byte,
  input  logic                         ld_last,
  output logic                         cpu_hold,
  output state_e                       dbg_state,
  output logic [$clog2(MEM_BYTES)-1:0] dbg_ptr
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int RW = AW - LANE_IDX_W;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [AW-1:0]         r_ptr;
  logic                  r_rd_vld;
  logic [LANE_IDX_W-1:0] r_rot;

  logic                  w_ld_fire;
  logic                  w_cpu_we;
  logic [AW-1:0]         w_a;

  logic [LANE_IDX_W-1:0] w_lane      [LANES];
  logic [AW-1:0]         w_byte_addr [LANES];
  logic [RW-1:0]         w_bank_row  [LANES];
  logic [7:0]            w_bank_wdata[LANES];
  logic                  w_bank_we   [LANES];
  logic [7:0]            w_bank_rdata[LANES];

  // Only the low address bits select a byte; the rest alias.
  assign w_a = addr[AW-1:0];

  generate
    if (M_WIDTH > AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^addr[M_WIDTH-1:AW];
    end
  endgenerate

  assign w_ld_fire = ld_valid && (r_state == ST_LOAD) && !rst;
  assign w_cpu_we  = we && (r_state == ST_RUN) && !rst;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake/hold outputs; leave LOAD after the last byte
  // or once the final byte of the memory has been filled.
  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b0;
    cpu_hold    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (w_ld_fire && (ld_last || (r_ptr == '1))) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Load pointer and read-return bookkeeping (valid flag, lane rotation).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_rd_vld <= 1'b0;
      r_rot    <= '0;
    end else begin
      if (w_ld_fire) begin
        r_ptr <= r_ptr + AW'(1);
      end
      r_rd_vld <= (r_state == ST_RUN);
      r_rot    <= w_a[LANE_IDX_W-1:0];
    end
  end

  // Per-bank row, write data and write enable. Bank k carries lane
  // (k - a[1:0]) mod 4, i.e. byte address a + lane (wrapping).
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lane[k]       = '0;
      w_byte_addr[k]  = '0;
      w_bank_row[k]   = '0;
      w_bank_wdata[k] = '0;
      w_bank_we[k]    = 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      w_lane[k]      = LANE_IDX_W'(k) - w_a[LANE_IDX_W-1:0];
      w_byte_addr[k] = w_a + {{(AW-LANE_IDX_W){1'b0}}, w_lane[k]};
      if (r_state == ST_LOAD) begin
        w_bank_row[k]   = r_ptr[AW-1:LANE_IDX_W];
        w_bank_wdata[k] = ld_byte;
        w_bank_we[k]    = w_ld_fire && (r_ptr[LANE_IDX_W-1:0] == LANE_IDX_W'(k));
      end else begin
        w_bank_row[k]   = w_byte_addr[k][AW-1:LANE_IDX_W];
        w_bank_wdata[k] = lane_byte(data_in, w_lane[k]);
        w_bank_we[k]    = w_cpu_we;
      end
    end
  end

  // Reassemble the big-endian read word from the banks; zero until a
  // read issued in RUN has returned.
  always_comb begin
    data_out = '0;
    if (r_rd_vld) begin
      for (int j = 0; j < LANES; j++) begin
        data_out[BYTE_W*(LANE_LSB-j) +: BYTE_W] =
          w_bank_rdata[lane_bank(r_rot, LANE_IDX_W'(j))];
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_bank
      byte_bank #(
        .ROW_W (RW)
      ) u_bank (
        .i_clk   (clk),
        .i_addr  (w_bank_row[g]),
        .i_we    (w_bank_we[g]),
        .i_wdata (w_bank_wdata[g]),
        .o_rdata (w_bank_rdata[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot load, aligned/unaligned and
// wrapping accesses, read-old, reset behaviour and full-memory load.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        we = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        cpu_hold;
  state_e      dbg_state;
  logic [11:0] dbg_ptr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .M_WIDTH   (32),
    .MEM_BYTES (4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .we        (we),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .cpu_hold  (cpu_hold),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    we       = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    we      = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    we   = 1'b0;
    step();
    v = data_out;
  endtask

  task automatic test_reset();
    do_rst();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    end
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold);
    end
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL reset_data_out: got %h expected 00000000", data_out);
    end
    checks++;
    if (dbg_state !== ST_LOAD || dbg_ptr !== 12'h0) begin
      errors++; $display("FAIL reset_state_ptr: got %0d/%h expected 0/000", dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_load();
    logic [7:0]  img [4];
    logic [31:0] v;
    img[0] = 8'h50; img[1] = 8'h01; img[2] = 8'h51; img[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = (i == 3);
      #1;
      checks++;
      if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
        errors++; $display("FAIL load_ready_hold_%0d: got %b/%b expected 1/1", i, ld_ready, cpu_hold);
      end
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++; $display("FAIL load_enter_run: hold=%b ready=%b state=%0d expected 0/0/1", cpu_hold, ld_ready, dbg_state);
    end
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL load_first_run_data: got %h expected 00000000", data_out);
    end
    rd(32'h0, v);
    checks++;
    if (v !== 32'h50015100) begin
      errors++; $display("FAIL load_read0: got %h expected 50015100", v);
    end
    // Loader inputs are ignored in RUN.
    ld_valid = 1'b1;
    ld_byte  = 8'hEE;
    rd(32'h0, v);
    ld_valid = 1'b0;
    checks++;
    if (v !== 32'h50015100 || dbg_ptr !== 12'h004) begin
      errors++; $display("FAIL run_ignores_loader: got %h ptr %h expected 50015100 ptr 004", v, dbg_ptr);
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] v;
    wr(32'hE4, 32'h55667788);
    wr(32'hE0, 32'h01020304);
    rd(32'hE1, v);
    checks++;
    if (v !== 32'h02030455) begin
      errors++; $display("FAIL unaligned_e1: got %h expected 02030455", v);
    end
    rd(32'hE3, v);
    checks++;
    if (v !== 32'h04556677) begin
      errors++; $display("FAIL unaligned_e3: got %h expected 04556677", v);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(32'h000, 32'h99887766);
    wr(32'hFFC, 32'h12345678);
    wr(32'hFFE, 32'hAABBCCDD);
    rd(32'h000, v);
    checks++;
    if (v !== 32'hCCDD7766) begin
      errors++; $display("FAIL wrap_read0: got %h expected CCDD7766", v);
    end
    rd(32'hFFC, v);
    checks++;
    if (v !== 32'h1234AABB) begin
      errors++; $display("FAIL wrap_readffc: got %h expected 1234AABB", v);
    end
    rd(32'hFFF, v);
    checks++;
    if (v !== 32'hBBCCDD77) begin
      errors++; $display("FAIL wrap_readfff: got %h expected BBCCDD77", v);
    end
    rd(32'h12345000, v);
    checks++;
    if (v !== 32'hCCDD7766) begin
      errors++; $display("FAIL high_addr_alias: got %h expected CCDD7766", v);
    end
  endtask

  task automatic test_read_old();
    logic [31:0] v;
    wr(32'h10, 32'h22222222);
    wr(32'h10, 32'h11111111);
    v = data_out;
    checks++;
    if (v !== 32'h22222222) begin
      errors++; $display("FAIL read_old_same_cycle: got %h expected 22222222", v);
    end
    rd(32'h10, v);
    checks++;
    if (v !== 32'h11111111) begin
      errors++; $display("FAIL read_old_next: got %h expected 11111111", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(32'h20, 32'hA1A2A3A4);
    wr(32'h20, 32'hB1B2B3B4);
    wr(32'h22, 32'hC1C2C3C4);
    rd(32'h20, v);
    checks++;
    if (v !== 32'hB1B2C1C2) begin
      errors++; $display("FAIL back_to_back: got %h expected B1B2C1C2", v);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] v;
    do_rst();
    checks++;
    if (cpu_hold !== 1'b1 || dbg_state !== ST_LOAD) begin
      errors++; $display("FAIL run_to_load_rst: hold=%b state=%0d expected 1/0", cpu_hold, dbg_state);
    end
    load_byte(8'hA0, 1'b0);
    load_byte(8'hA1, 1'b0);
    checks++;
    if (dbg_ptr !== 12'h002) begin
      errors++; $display("FAIL midload_ptr: got %h expected 002", dbg_ptr);
    end
    do_rst();
    checks++;
    if (dbg_ptr !== 12'h000 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL midload_rst: ptr %h hold %b expected 000/1", dbg_ptr, cpu_hold);
    end
    // CPU writes are ignored and data_out stays 0 in LOAD.
    wr(32'h10, 32'hDEADBEEF);
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL load_data_out_zero: got %h expected 00000000", data_out);
    end
    load_byte(8'hB0, 1'b0);
    load_byte(8'hB1, 1'b0);
    load_byte(8'hB2, 1'b0);
    load_byte(8'hB3, 1'b1);
    rd(32'h0, v);
    checks++;
    if (v !== 32'hB0B1B2B3) begin
      errors++; $display("FAIL reload_read0: got %h expected B0B1B2B3", v);
    end
    rd(32'h10, v);
    checks++;
    if (v !== 32'h11111111) begin
      errors++; $display("FAIL mem_persist_10: got %h expected 11111111", v);
    end
    rd(32'hE4, v);
    checks++;
    if (v !== 32'h55667788) begin
      errors++; $display("FAIL mem_persist_e4: got %h expected 55667788", v);
    end
  endtask

  task automatic test_full_load();
    logic [31:0] v;
    do_rst();
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(i) ^ 8'h5A;
      ld_last  = 1'b0;
      if (i == 4095) begin
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || dbg_state !== ST_LOAD) begin
          errors++; $display("FAIL full_hold_before_last: hold %b state %0d expected 1/0", cpu_hold, dbg_state);
        end
      end
      step();
    end
    ld_byte = 8'h00;
    checks++;
    if (dbg_state !== ST_RUN || dbg_ptr !== 12'h000 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL full_enter_run: state %0d ptr %h hold %b expected 1/000/0", dbg_state, dbg_ptr, cpu_hold);
    end
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++; $display("FAIL full_4097_ready: got %b expected 0", ld_ready);
    end
    step();
    ld_valid = 1'b0;
    rd(32'hFFE, v);
    checks++;
    if (v !== 32'hA4A55A5B) begin
      errors++; $display("FAIL full_read_ffe: got %h expected A4A55A5B", v);
    end
    rd(32'h000, v);
    checks++;
    if (v !== 32'h5A5B5859 || dbg_ptr !== 12'h000) begin
      errors++; $display("FAIL full_read0: got %h ptr %h expected 5A5B5859 ptr 000", v, dbg_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_unaligned();
    test_wrap();
    test_read_old();
    test_back_to_back();
    test_reset_mid_load();
    test_full_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter M_WIDTH, default 32: address bus width; only the low 12 bits are decoded.
REQ-002 Parameter MEM_BYTES, default 4096: byte capacity; it SHALL be a power of two and a multiple of 4.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 addr  input  M_WIDTH  byte address of the 32-bit access from the CPU.
REQ-006 data_in  input  32  CPU write data, big-endian (bits 31:24 go to addr).
REQ-007 data_out  output  32  registered read data to the CPU, big-endian.
REQ-008 we  input  1  CPU write enable for the current cycle.
REQ-009 ld_valid  input  1  loader byte valid.
REQ-010 ld_ready  output  1  loader byte accepted when ld_valid and ld_ready are both high.
REQ-011 ld_byte  input  8  loader byte value.
REQ-012 ld_last  input  1  marks the final loader byte; qualified by ld_valid.
REQ-013 cpu_hold  output  1  high while the CPU must be held in reset (image not yet loaded).

Function
REQ-014 The FSM SHALL have the states LOAD and RUN.
REQ-015 In LOAD, ld_ready SHALL be 1 and cpu_hold SHALL be 1; each accepted byte SHALL be written to mem[ptr], and ptr SHALL then increment.
REQ-016 LOAD->RUN SHALL occur on the cycle after an accepted byte with ld_last=1, or after an accepted byte at ptr=MEM_BYTES-1 (ptr wraps to 0); cpu_hold SHALL drop in that same cycle.
REQ-017 In RUN, ld_ready SHALL be 0 and cpu_hold SHALL be 0; loader inputs SHALL be ignored; RUN SHALL persist until rst.
REQ-018 In LOAD, CPU we SHALL be ignored and data_out SHALL hold 0.
REQ-019 RUN read: data_out SHALL equal {mem[a],mem[a+1],mem[a+2],mem[a+3]} one cycle after addr is presented, where a = addr mod MEM_BYTES; latency is exactly 1 and there are no stalls.
REQ-020 RUN write: when we=1, mem[a..a+3] SHALL receive data_in[31:24], [23:16], [15:8], [7:0] at that posedge.
REQ-021 Addresses a+k SHALL wrap modulo MEM_BYTES (a=4094 touches 4094, 4095, 0, 1).
REQ-022 Unaligned addresses SHALL be fully supported in a single cycle, with no penalty.
REQ-023 A read with we=1 in the same cycle SHALL return the pre-write contents (read-old).
REQ-024 Back-to-back writes followed by a read of the same address SHALL return the latest written data.

Reset
REQ-025 On rst: state=LOAD, ptr=0, data_out=0, ld_ready=1, cpu_hold=1.
REQ-026 Memory contents SHALL NOT be cleared by rst.
REQ-027 rst during LOAD SHALL restart ptr at 0; already-loaded bytes persist until they are overwritten.
REQ-028 rst during RUN SHALL return to LOAD; the CPU is held again.

Structure
REQ-029 The shared package SHALL hold LANES=4, the state enum {LOAD,RUN}, and the byte-lane index helper constants.
REQ-030 Memory SHALL be four byte-wide banks; byte address b SHALL map to bank b%4 at row b/4.
REQ-031 Each access SHALL compute a per-bank row and a lane rotation from a[1:0].
REQ-032 One sub-module SHALL be used: byte_bank, a MEM_BYTES/4 x 8 synchronous single-port RAM with read-old behaviour, instantiated four times.
REQ-033 The lane rotate for read and write data SHALL be combinational in the parent.

Verification
REQ-034 Reset, then stream bytes 50 01 51 00 with ld_last on the 4th -> ld_ready high for 4 cycles; cpu_hold falls the cycle after; reading addr 0 gives data_out=0x50015100 one cycle later.
REQ-035 RUN, we=1, addr=0xE0, data_in=0x01020304, then read 0xE1 -> 0x020304xx, where xx is the prior contents of 0xE4.
REQ-036 RUN, write 0xAABBCCDD at addr 0xFFE (MEM_BYTES=4096) -> mem[0xFFE]=AA, mem[0xFFF]=BB, mem[0]=CC, mem[1]=DD; reading 0 returns 0xCCDDxxxx.
REQ-037 Same-cycle write 0x11111111 and read at 0x10 holding 0x22222222 -> data_out=0x22222222; the next read returns 0x11111111.
REQ-038 Assert rst after 2 of 4 loader bytes -> ptr restarts at 0, cpu_hold stays 1; reloading 4 bytes overwrites addresses 0-3.
REQ-039 Load 4096 bytes without ld_last -> RUN is entered after byte 4095, ptr=0, and a 4097th ld_valid is not accepted (ld_ready=0).
